pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/pc_next_sel.sv | 29 ++
 rtl/pc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
package riscv_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StTrap = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    CauseNone       = 2'd0,
    CauseMisaligned = 2'd1,
    CauseTimeout    = 2'd2
  } trap_cause_e;

  localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
  localparam logic [31:0] DefaultTrapVector  = 32'h0000_0100;
  localparam int unsigned DefaultMaxWait     = 15;
  localparam logic [31:0] PcStep             = 32'd4;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection (jump > branch > sequential) with target alignment check.
module pc_next_sel
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        misaligned
);

  always_comb begin
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc + PcStep;
    end
  end

  assign redirect   = jump | branch_taken;
  // Sequential pc+4 stays aligned, so only redirect targets are checked.
  assign misaligned = redirect & addr_misaligned(next_pc);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues instruction fetches, follows redirects, raises traps.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DefaultResetVector,
  parameter logic [31:0] TRAP_VECTOR  = DefaultTrapVector,
  parameter int unsigned MAX_WAIT     = DefaultMaxWait
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] bad_addr,
  output logic [31:0] fetch_count
);

  localparam logic [7:0] MaxWaitM1 = 8'(MAX_WAIT - 1);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        instr_valid_q, instr_valid_d;
  trap_cause_e cause_q, cause_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  logic [31:0] next_pc;
  logic        redirect;
  logic        misaligned;
  logic        active;
  logic        fetch_done;
  logic        wait_miss;
  logic        timeout;

  pc_next_sel u_pc_next_sel (
    .pc            (pc_q),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .misaligned    (misaligned)
  );

  assign active     = (state_q == StReq) || (state_q == StWait);
  // A redirect aborts the outstanding fetch even if memory is ready this cycle.
  assign fetch_done = !redirect && imem_ready &&
                      ((state_q == StWait) || ((state_q == StReq) && !stall));
  assign wait_miss  = (state_q == StWait) && !redirect && !imem_ready;
  assign timeout    = wait_miss && (wait_cnt_q == MaxWaitM1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (redirect) begin
          state_d = misaligned ? StTrap : StReq;
        end else if (!stall && !imem_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          state_d = misaligned ? StTrap : StReq;
        end else if (imem_ready) begin
          state_d = StReq;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StTrap:  state_d = StReq;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    cause_d       = cause_q;
    bad_addr_d    = bad_addr_q;
    instr_valid_d = fetch_done;
    wait_cnt_d    = wait_miss ? wait_cnt_q + 8'd1 : 8'd0;
    if (state_q == StTrap) begin
      pc_d = TRAP_VECTOR;
    end else if (active && redirect) begin
      if (misaligned) begin
        cause_d    = CauseMisaligned;
        bad_addr_d = next_pc;
      end else begin
        pc_d = next_pc;
      end
    end else if (fetch_done) begin
      pc_d          = next_pc;
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (timeout) begin
      cause_d    = CauseTimeout;
      bad_addr_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      wait_cnt_q    <= 8'd0;
      fetch_count_q <= 32'd0;
      instr_valid_q <= 1'b0;
      cause_q       <= CauseNone;
      bad_addr_q    <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_count_q <= fetch_count_d;
      instr_valid_q <= instr_valid_d;
      cause_q       <= cause_d;
      bad_addr_q    <= bad_addr_d;
    end
  end

  // Outputs; pulses and request are forced low while reset is held.
  always_comb begin
    imem_req = 1'b0;
    trap     = 1'b0;
    unique case (state_q)
      StReq:   imem_req = !stall;
      StWait:  imem_req = 1'b1;
      StTrap:  trap     = 1'b1;
      default: ;
    endcase
    if (reset) begin
      imem_req = 1'b0;
      trap     = 1'b0;
    end
  end

  assign instr_valid = instr_valid_q && !reset;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign trap_cause  = cause_q;
  assign bad_addr    = bad_addr_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] bad_addr;
  logic [31:0] fetch_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .instr_valid   (instr_valid),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .bad_addr      (bad_addr),
    .fetch_count   (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b0;
    jump = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_target = '0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_trap", {31'd0, trap}, 32'd0);
    check_eq("rst_cause", {30'd0, trap_cause}, 32'd0);
    check_eq("rst_bad", bad_addr, 32'h0);
    check_eq("rst_cnt", fetch_count, 32'd0);

    // Sequential fetch with ready tied high
    reset = 1'b0; imem_ready = 1'b1;
    #1 check_eq("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check_eq("seq_req0", {31'd0, imem_req}, 32'd1);
    check_eq("seq_addr0", imem_addr, 32'h0);
    check_eq("seq_iv0", {31'd0, instr_valid}, 32'd0);
    tick();
    check_eq("seq_addr1", imem_addr, 32'h4);
    check_eq("seq_iv1", {31'd0, instr_valid}, 32'd1);
    tick();
    check_eq("seq_addr2", imem_addr, 32'h8);
    check_eq("seq_iv2", {31'd0, instr_valid}, 32'd1);
    tick();
    check_eq("seq_cnt3", fetch_count, 32'd3);
    check_eq("seq_pc3", pc, 32'hC);

    // Stall for three cycles in REQ
    stall = 1'b1;
    #1 check_eq("stall_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc", pc, 32'hC);
      check_eq("stall_cnt", fetch_count, 32'd3);
      check_eq("stall_iv", {31'd0, instr_valid}, 32'd0);
      check_eq("stall_req_n", {31'd0, imem_req}, 32'd0);
    end

    // REQ -> WAIT, stall ignored in WAIT, then complete
    stall = 1'b0; imem_ready = 1'b0;
    tick();
    stall = 1'b1;
    #1 check_eq("wait_req_stall", {31'd0, imem_req}, 32'd1);
    check_eq("wait_pc", pc, 32'hC);
    stall = 1'b0; imem_ready = 1'b1;
    tick();
    check_eq("wait_done_pc", pc, 32'h10);
    check_eq("wait_done_iv", {31'd0, instr_valid}, 32'd1);
    check_eq("wait_done_cnt", fetch_count, 32'd4);

    // Jump beats branch in the same cycle
    imem_ready = 1'b0;
    jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    check_eq("prio_pc", pc, 32'h40);
    check_eq("prio_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("prio_cnt", fetch_count, 32'd4);

    // Redirect overrides stall
    jump = 1'b0; stall = 1'b1;
    tick();
    check_eq("redir_stall_pc", pc, 32'h80);

    // Redirect out of WAIT without ready
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    jump = 1'b1; jump_target = 32'h20;
    tick();
    jump = 1'b0;
    check_eq("wait_redir_pc", pc, 32'h20);
    check_eq("wait_redir_iv", {31'd0, instr_valid}, 32'd0);
    check_eq("wait_redir_cnt", fetch_count, 32'd4);

    // Fetch timeout at 0x20: REQ cycle then 15 WAIT cycles without ready
    for (int i = 0; i < 15; i++) begin
      tick();
      check_eq("to_no_trap", {31'd0, trap}, 32'd0);
    end
    tick();
    check_eq("to_trap", {31'd0, trap}, 32'd1);
    check_eq("to_cause", {30'd0, trap_cause}, 32'd2);
    check_eq("to_bad", bad_addr, 32'h20);
    check_eq("to_req", {31'd0, imem_req}, 32'd0);
    check_eq("to_iv", {31'd0, instr_valid}, 32'd0);
    jump = 1'b1; jump_target = 32'h44;
    tick();
    jump = 1'b0;
    check_eq("to_vec_pc", pc, 32'h100);
    check_eq("to_trap_end", {31'd0, trap}, 32'd0);
    check_eq("to_cause_held", {30'd0, trap_cause}, 32'd2);

    // Misaligned branch target
    branch_taken = 1'b1; branch_target = 32'h42;
    tick();
    branch_taken = 1'b0;
    check_eq("mis_trap", {31'd0, trap}, 32'd1);
    check_eq("mis_cause", {30'd0, trap_cause}, 32'd1);
    check_eq("mis_bad", bad_addr, 32'h42);
    tick();
    check_eq("mis_pc", pc, 32'h100);
    check_eq("mis_trap_end", {31'd0, trap}, 32'd0);

    // Wrap from 0xFFFF_FFFC
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0; imem_ready = 1'b1;
    check_eq("wrap_pre", pc, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_cnt", fetch_count, 32'd5);

    // Reset asserted mid-WAIT
    imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h60;
    tick();
    jump = 1'b0;
    repeat (4) tick();
    check_eq("rw_pre_pc", pc, 32'h60);
    reset = 1'b1;
    #1 check_eq("rw_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 14; i++) begin
      tick();
      check_eq("rw_trap", {31'd0, trap}, 32'd0);
      check_eq("rw_iv", {31'd0, instr_valid}, 32'd0);
    end
    check_eq("rw_pc", pc, 32'h0);
    check_eq("rw_cnt", fetch_count, 32'd0);
    check_eq("rw_cause", {30'd0, trap_cause}, 32'd0);
    check_eq("rw_bad", bad_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
